// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO plus launch FSM feeding the UART Tx stage.
// Optional sticky overflow flag (ovf/ovf_clr) when UART_TXQ_OVF_FLAG_EN is defined.
module uart_tx_fifo_ctrl #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   ack_err
`ifdef UART_TXQ_OVF_FLAG_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               ack_err_q, ack_err_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               push_ok;
    logic               pop;

    assign push_ok = push && !full_q;

    // Launch FSM; the only place a byte leaves the FIFO.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        ack_err_d  = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0 && !tx_busy) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_d = 1'b1;
                tmr_d      = '0;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT)) begin
                    ack_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tmr_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tmr_q      <= tmr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ack_err_q  <= ack_err_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = cnt_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign ack_err  = ack_err_q;

`ifdef UART_TXQ_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Clear takes priority over a same-cycle dropped push.
    always_comb begin
        ovf_d = ovf_q | (push && full_q);
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
